macarray_tile_sched: RTL and testbench

Job-level scheduler that sits in front of the 4x4 MAC array top. It accepts one matrix job (M x T) * (T x N) with dimensions up to 2^DIM_W-1, splits it into tiles of at most TILE x TILE x TILE, and issues one START plus 12-bit MNT per tile. After each START it waits for the array's tile-done and tracks accumulation (first/last T-slice) so the output path knows when to clear and when to commit.

---
 rtl/macarray_tile_sched.sv | 162 ++++++++++++++++
 tb/tb_macarray_tile_sched.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/macarray_tile_sched.sv
// Job-level tile scheduler for the 4x4 MAC array: splits an (M x T)*(T x N) job
// into TILE-sized tiles, issues START+MNT per tile and tracks accumulation slices.
module macarray_tile_sched #(
  parameter int DIM_W = 8,
  parameter int TILE  = 4,
  parameter int IDX_W = 6
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               job_valid_i,
  output logic               job_ready_o,
  input  logic [DIM_W-1:0]   job_m_i,
  input  logic [DIM_W-1:0]   job_n_i,
  input  logic [DIM_W-1:0]   job_t_i,
  output logic               tile_start_o,
  output logic [11:0]        tile_mnt_o,
  input  logic               tile_done_i,
  output logic [IDX_W-1:0]   m_idx_o,
  output logic [IDX_W-1:0]   n_idx_o,
  output logic [IDX_W-1:0]   t_idx_o,
  output logic               acc_first_o,
  output logic               acc_last_o,
  output logic               busy_o,
  output logic               job_done_o,
  output logic               err_o
);

  localparam int XW = DIM_W + IDX_W + 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Tile edge along one axis: min(TILE, dim - TILE*idx), computed wide before the min.
  function automatic logic [3:0] tile_sz(input logic [DIM_W-1:0] dim,
                                         input logic [IDX_W-1:0] idx);
    logic [XW-1:0] rem;
    rem = XW'(dim) - XW'(idx) * XW'(TILE);
    if (rem > XW'(TILE)) tile_sz = 4'(TILE);
    else                 tile_sz = rem[3:0];
  endfunction

  function automatic logic [IDX_W-1:0] last_idx(input logic [DIM_W-1:0] dim);
    logic [XW-1:0] cnt;
    cnt = (XW'(dim) + XW'(TILE - 1)) / XW'(TILE);
    last_idx = IDX_W'(cnt - XW'(1));
  endfunction

  state_t             state_q;
  logic [DIM_W-1:0]   dim_m_q, dim_n_q, dim_t_q;
  logic [IDX_W-1:0]   m_last_q, n_last_q, t_last_q;
  logic [IDX_W-1:0]   m_idx_q, n_idx_q, t_idx_q;
  logic [11:0]        mnt_q;
  logic               start_q, ready_q, busy_q, done_q, err_q, first_q, last_q;

  logic               t_wrap, n_wrap, last_tile, any_zero;
  logic [IDX_W-1:0]   m_nx, n_nx, t_nx;

  assign t_wrap    = (t_idx_q == t_last_q);
  assign n_wrap    = (n_idx_q == n_last_q);
  assign last_tile = t_wrap && n_wrap && (m_idx_q == m_last_q);
  assign t_nx      = t_wrap ? '0 : t_idx_q + IDX_W'(1);
  assign n_nx      = t_wrap ? (n_wrap ? '0 : n_idx_q + IDX_W'(1)) : n_idx_q;
  assign m_nx      = (t_wrap && n_wrap) ? m_idx_q + IDX_W'(1) : m_idx_q;
  assign any_zero  = (job_m_i == '0) || (job_n_i == '0) || (job_t_i == '0);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= S_IDLE;
      dim_m_q  <= '0;
      dim_n_q  <= '0;
      dim_t_q  <= '0;
      m_last_q <= '0;
      n_last_q <= '0;
      t_last_q <= '0;
      m_idx_q  <= '0;
      n_idx_q  <= '0;
      t_idx_q  <= '0;
      mnt_q    <= '0;
      start_q  <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      // A tile-done outside WAIT never advances the schedule, it only flags.
      if (tile_done_i && (state_q != S_WAIT)) err_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (job_valid_i) begin
            dim_m_q  <= job_m_i;
            dim_n_q  <= job_n_i;
            dim_t_q  <= job_t_i;
            m_last_q <= last_idx(job_m_i);
            n_last_q <= last_idx(job_n_i);
            t_last_q <= last_idx(job_t_i);
            m_idx_q  <= '0;
            n_idx_q  <= '0;
            t_idx_q  <= '0;
            ready_q  <= 1'b0;
            if (any_zero) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_ISSUE;
              start_q <= 1'b1;
              busy_q  <= 1'b1;
              mnt_q   <= {tile_sz(job_m_i, '0), tile_sz(job_n_i, '0), tile_sz(job_t_i, '0)};
              first_q <= 1'b1;
              last_q  <= (last_idx(job_t_i) == '0);
            end
          end
        end
        S_ISSUE: state_q <= S_WAIT;
        S_WAIT: begin
          if (tile_done_i) begin
            if (last_tile) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= S_ISSUE;
              start_q <= 1'b1;
              m_idx_q <= m_nx;
              n_idx_q <= n_nx;
              t_idx_q <= t_nx;
              mnt_q   <= {tile_sz(dim_m_q, m_nx), tile_sz(dim_n_q, n_nx), tile_sz(dim_t_q, t_nx)};
              first_q <= (t_nx == '0);
              last_q  <= (t_nx == t_last_q);
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign job_ready_o  = ready_q;
  assign tile_start_o = start_q;
  assign tile_mnt_o   = mnt_q;
  assign m_idx_o      = m_idx_q;
  assign n_idx_o      = n_idx_q;
  assign t_idx_o      = t_idx_q;
  assign acc_first_o  = first_q;
  assign acc_last_o   = last_q;
  assign busy_o       = busy_q;
  assign job_done_o   = done_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_macarray_tile_sched.sv
// Bench for macarray_tile_sched: table-driven and random jobs against a
// nested-loop tiling model, plus hand-written reset/error/backpressure sequences.
module tb_macarray_tile_sched;
  localparam int DIM_W = 8;
  localparam int TILE  = 4;
  localparam int IDX_W = 6;

  logic             clk = 1'b0;
  logic             rstn;
  logic             job_valid;
  logic             job_ready;
  logic [DIM_W-1:0] job_m, job_n, job_t;
  logic             tile_start;
  logic [11:0]      tile_mnt;
  logic             tile_done;
  logic [IDX_W-1:0] m_idx, n_idx, t_idx;
  logic             acc_first, acc_last, busy, job_done, err;

  int n_chk  = 0;
  int n_fail = 0;

  macarray_tile_sched #(.DIM_W(DIM_W), .TILE(TILE), .IDX_W(IDX_W)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .job_valid_i(job_valid), .job_ready_o(job_ready),
    .job_m_i(job_m), .job_n_i(job_n), .job_t_i(job_t),
    .tile_start_o(tile_start), .tile_mnt_o(tile_mnt), .tile_done_i(tile_done),
    .m_idx_o(m_idx), .n_idx_o(n_idx), .t_idx_o(t_idx),
    .acc_first_o(acc_first), .acc_last_o(acc_last),
    .busy_o(busy), .job_done_o(job_done), .err_o(err)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          mi, ni, ti;
    logic [11:0] mnt;
    bit          first, last;
  } tile_t;

  typedef struct {
    int          m, n, t;
    int          tiles;
    logic [11:0] mnt_first, mnt_last;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int edge_sz(input int dim, input int idx);
    int r;
    r = dim - TILE * idx;
    return (r < TILE) ? r : TILE;
  endfunction

  // Issue one job and serve every tile; exp_tiles < 0 skips the table totals.
  task automatic run_job(input int m, input int n, input int t, input int dly,
                         input int exp_tiles, input logic [11:0] exp_f, input logic [11:0] exp_l);
    tile_t       q[$];
    tile_t       e;
    int          seen = 0;
    int          d;
    logic [11:0] mf = '0, ml = '0;
    for (int mi = 0; mi * TILE < m; mi++)
      for (int ni = 0; ni * TILE < n; ni++)
        for (int ti = 0; ti * TILE < t; ti++) begin
          e.mi = mi; e.ni = ni; e.ti = ti;
          e.mnt = {4'(edge_sz(m, mi)), 4'(edge_sz(n, ni)), 4'(edge_sz(t, ti))};
          e.first = (ti == 0);
          e.last  = ((ti + 1) * TILE >= t);
          q.push_back(e);
        end
    if (m == 0 || n == 0 || t == 0) q.delete();

    chk("ready_before_job", job_ready, 1);
    job_m = 8'(m); job_n = 8'(n); job_t = 8'(t);
    job_valid = 1'b1;
    @(negedge clk);
    job_valid = 1'b0;
    if (q.size() == 0) begin
      chk("zero_job_done", job_done, 1);
      chk("zero_no_start", tile_start, 0);
      chk("zero_not_busy", busy, 0);
    end else begin
      for (int k = 0; k < q.size(); k++) begin
        e = q[k];
        chk("tile_start", tile_start, 1);
        if (tile_start) seen++;
        chk("tile_mnt", tile_mnt, e.mnt);
        chk("m_idx", m_idx, e.mi);
        chk("n_idx", n_idx, e.ni);
        chk("t_idx", t_idx, e.ti);
        chk("acc_first", acc_first, e.first);
        chk("acc_last", acc_last, e.last);
        chk("busy_in_tile", busy, 1);
        chk("no_early_done", job_done, 0);
        if (k == 0) mf = tile_mnt;
        ml = tile_mnt;
        d = (dly > 0) ? dly : int'($urandom_range(1, 4));
        repeat (d) @(negedge clk);
        chk("start_one_cycle", tile_start, 0);
        chk("mnt_stable", tile_mnt, e.mnt);
        tile_done = 1'b1;
        @(negedge clk);
        tile_done = 1'b0;
      end
      chk("job_done_pulse", job_done, 1);
      chk("busy_clear_at_done", busy, 0);
      chk("no_start_at_done", tile_start, 0);
    end
    if (exp_tiles >= 0) begin
      chk("tile_count", seen, exp_tiles);
      if (exp_tiles > 0) begin
        chk("first_mnt", mf, exp_f);
        chk("last_mnt", ml, exp_l);
      end
    end
    @(negedge clk);
    chk("job_done_one_cycle", job_done, 0);
    chk("ready_after_job", job_ready, 1);
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{m:4,   n:4, t:4, tiles:1,   mnt_first:12'h444, mnt_last:12'h444};
    vecs[1] = '{m:5,   n:4, t:9, tiles:6,   mnt_first:12'h444, mnt_last:12'h141};
    vecs[2] = '{m:1,   n:1, t:1, tiles:1,   mnt_first:12'h111, mnt_last:12'h111};
    vecs[3] = '{m:8,   n:8, t:8, tiles:8,   mnt_first:12'h444, mnt_last:12'h444};
    vecs[4] = '{m:255, n:5, t:1, tiles:128, mnt_first:12'h441, mnt_last:12'h311};
    vecs[5] = '{m:3,   n:7, t:2, tiles:2,   mnt_first:12'h342, mnt_last:12'h332};
    vecs[6] = '{m:0,   n:3, t:3, tiles:0,   mnt_first:12'h000, mnt_last:12'h000};
    vecs[7] = '{m:2,   n:0, t:5, tiles:0,   mnt_first:12'h000, mnt_last:12'h000};
    vecs[8] = '{m:6,   n:6, t:0, tiles:0,   mnt_first:12'h000, mnt_last:12'h000};

    rstn = 1'b0; job_valid = 1'b0; tile_done = 1'b0;
    job_m = '0; job_n = '0; job_t = '0;
    repeat (3) @(negedge clk);
    chk("rst_start", tile_start, 0);
    chk("rst_mnt", tile_mnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", job_done, 0);
    chk("rst_err", err, 0);
    chk("rst_idx", {m_idx, n_idx, t_idx}, 0);
    chk("rst_acc", {acc_first, acc_last}, 0);
    rstn = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", job_ready, 1);

    run_job(4, 4, 4, 10, 1, 12'h444, 12'h444);
    for (int i = 0; i < 9; i++)
      run_job(vecs[i].m, vecs[i].n, vecs[i].t, 0, vecs[i].tiles, vecs[i].mnt_first, vecs[i].mnt_last);
    for (int i = 0; i < 15; i++)
      run_job(int'($urandom_range(0, 20)), int'($urandom_range(0, 20)), int'($urandom_range(0, 20)),
              0, -1, '0, '0);
    chk("err_clean_after_jobs", err, 0);

    // Stray tile-done while idle sets the sticky error; the next job is unaffected.
    tile_done = 1'b1;
    @(negedge clk);
    tile_done = 1'b0;
    chk("err_set_idle", err, 1);
    run_job(5, 4, 9, 0, 6, 12'h444, 12'h141);
    chk("err_sticky", err, 1);

    // Reset while waiting on the third of six tiles.
    job_m = 8'd5; job_n = 8'd4; job_t = 8'd9; job_valid = 1'b1;
    @(negedge clk);
    job_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      tile_done = 1'b1;
      @(negedge clk);
      tile_done = 1'b0;
    end
    @(negedge clk);
    chk("pre_reset_t_idx", t_idx, 2);
    chk("pre_reset_busy", busy, 1);
    rstn = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_idx", {m_idx, n_idx, t_idx}, 0);
    chk("midrst_mnt", tile_mnt, 0);
    chk("midrst_err", err, 0);
    chk("midrst_acc", {acc_first, acc_last}, 0);
    chk("midrst_done", job_done, 0);
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("no_done_after_reset", job_done, 0);
      chk("no_start_after_reset", tile_start, 0);
    end
    run_job(4, 4, 4, 0, 1, 12'h444, 12'h444);
    chk("err_clear_after_reset", err, 0);

    // Backpressure: valid held with new dims while the first job runs.
    job_m = 8'd4; job_n = 8'd4; job_t = 8'd4; job_valid = 1'b1;
    @(negedge clk);
    chk("bp_start1", tile_start, 1);
    chk("bp_mnt1", tile_mnt, 12'h444);
    job_m = 8'd2; job_n = 8'd3; job_t = 8'd1;
    chk("bp_ready_issue", job_ready, 0);
    @(negedge clk);
    chk("bp_ready_wait", job_ready, 0);
    chk("bp_no_relatch", tile_mnt, 12'h444);
    tile_done = 1'b1;
    @(negedge clk);
    tile_done = 1'b0;
    chk("bp_done1", job_done, 1);
    chk("bp_ready_done", job_ready, 0);
    @(negedge clk);
    chk("bp_ready_idle", job_ready, 1);
    chk("bp_no_start_idle", tile_start, 0);
    @(negedge clk);
    job_valid = 1'b0;
    chk("bp_start2", tile_start, 1);
    chk("bp_mnt2", tile_mnt, 12'h231);
    @(negedge clk);
    tile_done = 1'b1;
    @(negedge clk);
    tile_done = 1'b0;
    chk("bp_done2", job_done, 1);
    @(negedge clk);
    chk("bp_ready_end", job_ready, 1);

    // Tile-done during ISSUE flags an error and the scheduler still waits.
    job_m = 8'd4; job_n = 8'd4; job_t = 8'd4; job_valid = 1'b1;
    @(negedge clk);
    job_valid = 1'b0;
    tile_done = 1'b1;
    @(negedge clk);
    tile_done = 1'b0;
    chk("issue_done_err", err, 1);
    chk("issue_done_still_busy", busy, 1);
    chk("issue_done_no_jobdone", job_done, 0);
    @(negedge clk);
    chk("issue_done_waiting", busy, 1);
    tile_done = 1'b1;
    @(negedge clk);
    tile_done = 1'b0;
    chk("issue_done_finish", job_done, 1);
    @(negedge clk);
    chk("issue_done_ready", job_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
